mips_id_stage: RTL and testbench
================================

// Module: mips_id_stage
// PURPOSE
//  Decode stage downstream of MIPS_F1 fetch: IF/ID pipeline register, main control decoder,
//  32x32 register file, immediate extension and registered ID/EX outputs. Takes o_instruction
//  from fetch and the writeback port from WB; feeds execute. Stall/flush come from hazard unit.
// PARAMETERS
//  DATA_W    32   datapath/register width
//  NREGS     32   register file depth ($0 hardwired to zero)
// PORTS
//  clk           in   1   single clock, all state updates on posedge
//  reset         in   1   synchronous, active-high
//  i_valid       in   1   fetch presents a valid instruction this cycle
//  i_instruction in   32  instruction word from fetch
//  i_pc_plus4    in   32  PC+4 of that instruction
//  i_stall       in   1   hold IF/ID, insert bubble into ID/EX
//  i_flush       in   1   discard IF/ID contents (taken branch/jump)
//  i_wb_we       in   1   register file write enable
//  i_wb_addr     in   5   write register
//  i_wb_data     in   32  write data
//  o_valid       out  1   ID/EX holds a real instruction
//  o_pc_plus4    out  32  forwarded PC+4
//  o_rs_data     out  32  register[rs]
//  o_rt_data     out  32  register[rt]
//  o_imm         out  32  extended immediate
//  o_rs,o_rt,o_rd out 5   register fields
//  o_shamt       out  5   shift amount; o_funct out 6 function field
//  o_jaddr       out  26  jump target field
//  o_reg_dst,o_alu_src,o_mem_to_reg,o_reg_write,o_mem_read,o_mem_write,o_branch,o_jump out 1 controls
//  o_alu_op      out  3   000 add,001 sub,010 R-type(funct),011 and,100 or,101 slt
//  o_illegal     out  1   unknown opcode decoded (one-cycle flag, aligned with ID/EX)
// BEHAVIOUR
//  - Reset: IF/ID instr=0, valid=0; all ID/EX outputs 0; all 32 registers cleared to 0.
//  - IF/ID: flush -> instr=0,valid=0; else stall -> hold; else load i_instruction,i_valid.
//  - ID/EX: stall or flush or IF/ID invalid -> bubble (o_valid=0, all controls 0, data don't-care but 0);
//    else load decode of IF/ID. Flush has priority over stall when both asserted.
//  - Latency: instruction presented at edge N appears on ID/EX outputs after edge N+1 (2 edges).
//  - Decode (opcode): 000000 R: reg_dst,reg_write,alu_op=010; 100011 lw: alu_src,mem_to_reg,
//    reg_write,mem_read,add; 101011 sw: alu_src,mem_write,add; 000100 beq: branch,sub;
//    001000 addi: alu_src,reg_write,add; 001100 andi: and; 001101 ori: or; 001010 slti: slt
//    (andi/ori/slti also alu_src,reg_write); 000010 j: jump. Others: controls 0, o_illegal=1.
//  - R-type with instr==0 (NOP) is valid but reg_write=0 since rd=0 writes are suppressed.
//  - Immediate: zero-extend for andi/ori; sign-extend instr[15:0] otherwise.
//  - Register file: write on posedge when i_wb_we && i_wb_addr!=0; writes to $0 ignored.
//  - Read is write-through: same-cycle WB write to rs/rt is bypassed into ID/EX data.
//  - Register file keeps updating during stall/flush; only pipeline registers hold/clear.
//  - Reset mid-operation discards both pipeline registers and the whole register file.
// TESTING
//  1 Reset 5 cycles, then i_valid=0 -> o_valid=0, all controls 0, regs read 0.
//  2 WB write $8=0x0000_00AA, then fetch 0x2109_0005 (addi $9,$8,5) -> two edges later
//    o_rs_data=0xAA, o_imm=5, alu_src=1, reg_write=1, alu_op=000, o_rt=9.
//  3 Same-cycle WB write $8=0x1234 while decoding add $10,$8,$0 -> o_rs_data=0x1234.
//  4 lw 0x8D09_FFFC -> o_imm=0xFFFF_FFFC, mem_read=1, mem_to_reg=1; ori 0x3509_8000 -> o_imm=0x0000_8000.
//  5 Stall 2 cycles mid-stream -> IF/ID held, o_valid=0 for 2 cycles, held instr issues next;
//    stall+flush together -> instruction lost, o_valid=0.
//  6 WB write to $0 with 0xFFFF_FFFF -> later read of $0 returns 0; opcode 111111 -> o_illegal=1.

Source files
------------

// File: rtl/mips_id_stage.sv
// mips_id_stage: MIPS instruction decode stage.
//   Holds the IF/ID pipeline register, the main control decoder, a register file
//   with $0 tied to zero, immediate extension, and the registered ID/EX outputs.
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   i_valid/i_instruction/i_pc_plus4   instruction from fetch
//   i_stall, i_flush      hazard controls (flush wins over stall)
//   i_wb_we/i_wb_addr/i_wb_data        register file write port from writeback
//   o_*                   registered ID/EX payload and control signals for execute
module mips_id_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  input  logic [31:0]       i_instruction,
  input  logic [31:0]       i_pc_plus4,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_wb_we,
  input  logic [4:0]        i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic              o_valid,
  output logic [31:0]       o_pc_plus4,
  output logic [DATA_W-1:0] o_rs_data,
  output logic [DATA_W-1:0] o_rt_data,
  output logic [DATA_W-1:0] o_imm,
  output logic [4:0]        o_rs,
  output logic [4:0]        o_rt,
  output logic [4:0]        o_rd,
  output logic [4:0]        o_shamt,
  output logic [5:0]        o_funct,
  output logic [25:0]       o_jaddr,
  output logic              o_reg_dst,
  output logic              o_alu_src,
  output logic              o_mem_to_reg,
  output logic              o_reg_write,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic              o_branch,
  output logic              o_jump,
  output logic [2:0]        o_alu_op,
  output logic              o_illegal
);

  localparam int unsigned IMM_W = 16;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_FUNC = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;

  typedef struct packed {
    logic              valid;
    logic [31:0]       pc_plus4;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [5:0]        funct;
    logic [25:0]       jaddr;
    logic              reg_dst;
    logic              alu_src;
    logic              mem_to_reg;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              jump;
    logic [2:0]        alu_op;
    logic              illegal;
  } idex_t;

  logic [31:0]       ifid_instr_q, ifid_instr_d;
  logic [31:0]       ifid_pc_q,    ifid_pc_d;
  logic              ifid_valid_q, ifid_valid_d;
  idex_t             idex_q, idex_d, dec;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic              wb_wr;
  logic [5:0]        opcode;
  logic [4:0]        f_rs, f_rt, f_rd;
  logic [DATA_W-1:0] rs_val, rt_val;

  assign wb_wr  = i_wb_we && (i_wb_addr != 5'd0);
  assign opcode = ifid_instr_q[31:26];
  assign f_rs   = ifid_instr_q[25:21];
  assign f_rt   = ifid_instr_q[20:16];
  assign f_rd   = ifid_instr_q[15:11];

  // IF/ID next state: flush clears, stall holds, otherwise capture fetch.
  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    if (i_flush) begin
      ifid_instr_d = '0;
      ifid_pc_d    = '0;
      ifid_valid_d = 1'b0;
    end else if (!i_stall) begin
      ifid_instr_d = i_instruction;
      ifid_pc_d    = i_pc_plus4;
      ifid_valid_d = i_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_instr_q <= '0;
      ifid_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  // Register file; $0 is never written so it always reads as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_wr) begin
      regs_q[i_wb_addr] <= i_wb_data;
    end
  end

  // Write-through read: a writeback landing this cycle is seen by the decode.
  always_comb begin
    rs_val = regs_q[f_rs];
    rt_val = regs_q[f_rt];
    if (f_rs == 5'd0) begin
      rs_val = '0;
    end else if (wb_wr && (i_wb_addr == f_rs)) begin
      rs_val = i_wb_data;
    end
    if (f_rt == 5'd0) begin
      rt_val = '0;
    end else if (wb_wr && (i_wb_addr == f_rt)) begin
      rt_val = i_wb_data;
    end
  end

  // Main control decoder and field extraction for the instruction in IF/ID.
  always_comb begin
    dec          = '0;
    dec.valid    = 1'b1;
    dec.pc_plus4 = ifid_pc_q;
    dec.rs_data  = rs_val;
    dec.rt_data  = rt_val;
    dec.rs       = f_rs;
    dec.rt       = f_rt;
    dec.rd       = f_rd;
    dec.shamt    = ifid_instr_q[10:6];
    dec.funct    = ifid_instr_q[5:0];
    dec.jaddr    = ifid_instr_q[25:0];
    dec.imm      = {{(DATA_W-IMM_W){ifid_instr_q[15]}}, ifid_instr_q[15:0]};
    dec.alu_op   = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        dec.reg_dst   = 1'b1;
        // rd=$0 writes are dropped anyway; keeping reg_write low makes NOP inert.
        dec.reg_write = (f_rd != 5'd0);
        dec.alu_op    = ALU_FUNC;
      end
      OP_LW: begin
        dec.alu_src    = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
      end
      OP_SW: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
      end
      OP_BEQ: begin
        dec.branch = 1'b1;
        dec.alu_op = ALU_SUB;
      end
      OP_ADDI: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_ANDI: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = ALU_AND;
        dec.imm       = {{(DATA_W-IMM_W){1'b0}}, ifid_instr_q[15:0]};
      end
      OP_ORI: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = ALU_OR;
        dec.imm       = {{(DATA_W-IMM_W){1'b0}}, ifid_instr_q[15:0]};
      end
      OP_SLTI: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = ALU_SLT;
      end
      OP_J: begin
        dec.jump = 1'b1;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

  // ID/EX: bubble (all zero) on stall, flush, or an empty IF/ID.
  always_comb begin
    idex_d = dec;
    if (i_stall || i_flush || !ifid_valid_q) begin
      idex_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign o_valid      = idex_q.valid;
  assign o_pc_plus4   = idex_q.pc_plus4;
  assign o_rs_data    = idex_q.rs_data;
  assign o_rt_data    = idex_q.rt_data;
  assign o_imm        = idex_q.imm;
  assign o_rs         = idex_q.rs;
  assign o_rt         = idex_q.rt;
  assign o_rd         = idex_q.rd;
  assign o_shamt      = idex_q.shamt;
  assign o_funct      = idex_q.funct;
  assign o_jaddr      = idex_q.jaddr;
  assign o_reg_dst    = idex_q.reg_dst;
  assign o_alu_src    = idex_q.alu_src;
  assign o_mem_to_reg = idex_q.mem_to_reg;
  assign o_reg_write  = idex_q.reg_write;
  assign o_mem_read   = idex_q.mem_read;
  assign o_mem_write  = idex_q.mem_write;
  assign o_branch     = idex_q.branch;
  assign o_jump       = idex_q.jump;
  assign o_alu_op     = idex_q.alu_op;
  assign o_illegal    = idex_q.illegal;

endmodule

// File: tb/tb_mips_id_stage.sv
// tb_mips_id_stage: self-checking bench for mips_id_stage with a reference model
// of the decode stage (opcode table, register array, one-slot IF/ID).
module tb_mips_id_stage;

  localparam int unsigned VW = 193;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_valid = 1'b0;
  logic [31:0] i_instruction = '0;
  logic [31:0] i_pc_plus4 = '0;
  logic        i_stall = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_wb_we = 1'b0;
  logic [4:0]  i_wb_addr = '0;
  logic [31:0] i_wb_data = '0;
  logic        o_valid;
  logic [31:0] o_pc_plus4, o_rs_data, o_rt_data, o_imm;
  logic [4:0]  o_rs, o_rt, o_rd, o_shamt;
  logic [5:0]  o_funct;
  logic [25:0] o_jaddr;
  logic        o_reg_dst, o_alu_src, o_mem_to_reg, o_reg_write;
  logic        o_mem_read, o_mem_write, o_branch, o_jump;
  logic [2:0]  o_alu_op;
  logic        o_illegal;

  int checks = 0;
  int errors = 0;

  logic [31:0]   mregs [32];
  logic          mv;
  logic [31:0]   mins, mpc;
  logic [31:0]   pc_ctr = 32'h0000_1000;
  logic [VW-1:0] exp_vec;

  always #5 clk = ~clk;

  mips_id_stage dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_instruction(i_instruction),
    .i_pc_plus4(i_pc_plus4), .i_stall(i_stall), .i_flush(i_flush),
    .i_wb_we(i_wb_we), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .o_valid(o_valid), .o_pc_plus4(o_pc_plus4), .o_rs_data(o_rs_data),
    .o_rt_data(o_rt_data), .o_imm(o_imm), .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd),
    .o_shamt(o_shamt), .o_funct(o_funct), .o_jaddr(o_jaddr),
    .o_reg_dst(o_reg_dst), .o_alu_src(o_alu_src), .o_mem_to_reg(o_mem_to_reg),
    .o_reg_write(o_reg_write), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_branch(o_branch), .o_jump(o_jump), .o_alu_op(o_alu_op), .o_illegal(o_illegal)
  );

  function automatic logic [VW-1:0] dut_vec();
    return {o_valid, o_pc_plus4, o_rs_data, o_rt_data, o_imm, o_rs, o_rt, o_rd,
            o_shamt, o_funct, o_jaddr, o_reg_dst, o_alu_src, o_mem_to_reg,
            o_reg_write, o_mem_read, o_mem_write, o_branch, o_jump, o_alu_op, o_illegal};
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] r, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd);
    if (r == 5'd0) return 32'd0;
    if (we && wa == r) return wd;
    return mregs[r];
  endfunction

  // Expected ID/EX contents for an instruction decoded with the given WB activity.
  function automatic logic [VW-1:0] model_out(input logic v, input logic [31:0] ins,
                                              input logic [31:0] pc, input logic we,
                                              input logic [4:0] wa, input logic [31:0] wd);
    logic [5:0]  opc;
    logic [7:0]  ctl;  // reg_dst alu_src mem_to_reg reg_write mem_read mem_write branch jump
    logic [2:0]  aop;
    logic        ill;
    logic [31:0] imm;
    if (!v) return '0;
    opc = ins[31:26];
    ctl = 8'b0;
    aop = 3'b000;
    ill = 1'b0;
    imm = {{16{ins[15]}}, ins[15:0]};
    case (opc)
      6'h00: begin ctl = {3'b100, ins[15:11] != 5'd0, 4'b0000}; aop = 3'b010; end
      6'h23: ctl = 8'b0111_1000;
      6'h2B: ctl = 8'b0100_0100;
      6'h04: begin ctl = 8'b0000_0010; aop = 3'b001; end
      6'h08: ctl = 8'b0101_0000;
      6'h0C: begin ctl = 8'b0101_0000; aop = 3'b011; imm = {16'd0, ins[15:0]}; end
      6'h0D: begin ctl = 8'b0101_0000; aop = 3'b100; imm = {16'd0, ins[15:0]}; end
      6'h0A: begin ctl = 8'b0101_0000; aop = 3'b101; end
      6'h02: ctl = 8'b0000_0001;
      default: ill = 1'b1;
    endcase
    return {1'b1, pc, model_read(ins[25:21], we, wa, wd), model_read(ins[20:16], we, wa, wd),
            imm, ins[25:21], ins[20:16], ins[15:11], ins[10:6], ins[5:0], ins[25:0],
            ctl, aop, ill};
  endfunction

  // Drive one cycle, advance the model, and leave exp_vec holding the expected outputs.
  task automatic step(input logic v, input logic [31:0] ins, input logic st, input logic fl,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd);
    pc_ctr        = pc_ctr + 32'd4;
    i_valid       = v;
    i_instruction = ins;
    i_pc_plus4    = pc_ctr;
    i_stall       = st;
    i_flush       = fl;
    i_wb_we       = we;
    i_wb_addr     = wa;
    i_wb_data     = wd;
    exp_vec = (st || fl) ? '0 : model_out(mv, mins, mpc, we, wa, wd);
    if (fl) begin
      mv = 1'b0; mins = '0; mpc = '0;
    end else if (!st) begin
      mv = v; mins = ins; mpc = pc_ctr;
    end
    if (we && wa != 5'd0) mregs[wa] = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] ins);
    step(1'b1, ins, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic idle();
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    mv = 1'b0; mins = '0; mpc = '0;
    exp_vec = '0;
  endtask

  task automatic test_reset();
    do_reset(5);
    checks++;
    if (dut_vec() !== exp_vec) begin
      errors++; $display("FAIL reset_state got %h exp %h", dut_vec(), exp_vec);
    end
    idle();
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL reset_idle_valid got %b exp 0", o_valid);
    end
    fetch(32'h0043_0820);  // add $1,$2,$3
    idle();
    checks++;
    if (o_rs_data !== 32'd0 || o_rt_data !== 32'd0 || o_valid !== 1'b1) begin
      errors++; $display("FAIL reset_regs got rs %h rt %h v %b exp 0 0 1", o_rs_data, o_rt_data, o_valid);
    end
    checks++;
    if (dut_vec() !== exp_vec) begin
      errors++; $display("FAIL reset_read_vec got %h exp %h", dut_vec(), exp_vec);
    end
  endtask

  task automatic test_addi();
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd8, 32'h0000_00AA);
    fetch(32'h2109_0005);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL addi_latency got valid %b exp 0", o_valid);
    end
    idle();
    checks++;
    if (o_rs_data !== 32'hAA || o_imm !== 32'd5 || o_alu_src !== 1'b1 || o_reg_write !== 1'b1 ||
        o_alu_op !== 3'b000 || o_rt !== 5'd9) begin
      errors++; $display("FAIL addi_fields got rs %h imm %h src %b wr %b op %b rt %0d exp aa 5 1 1 000 9",
                         o_rs_data, o_imm, o_alu_src, o_reg_write, o_alu_op, o_rt);
    end
    checks++;
    if (dut_vec() !== exp_vec) begin
      errors++; $display("FAIL addi_vec got %h exp %h", dut_vec(), exp_vec);
    end
  endtask

  task automatic test_bypass();
    fetch(32'h0100_5020);  // add $10,$8,$0
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd8, 32'h0000_1234);
    checks++;
    if (o_rs_data !== 32'h1234 || o_reg_write !== 1'b1 || o_alu_op !== 3'b010) begin
      errors++; $display("FAIL bypass got rs %h wr %b op %b exp 1234 1 010", o_rs_data, o_reg_write, o_alu_op);
    end
    checks++;
    if (dut_vec() !== exp_vec) begin
      errors++; $display("FAIL bypass_vec got %h exp %h", dut_vec(), exp_vec);
    end
  endtask

  task automatic test_imm_ext();
    fetch(32'h8D09_FFFC);
    fetch(32'h3509_8000);
    checks++;
    if (o_imm !== 32'hFFFF_FFFC || o_mem_read !== 1'b1 || o_mem_to_reg !== 1'b1) begin
      errors++; $display("FAIL lw_sext got imm %h mr %b m2r %b exp fffffffc 1 1", o_imm, o_mem_read, o_mem_to_reg);
    end
    idle();
    checks++;
    if (o_imm !== 32'h0000_8000 || o_alu_op !== 3'b100) begin
      errors++; $display("FAIL ori_zext got imm %h op %b exp 00008000 100", o_imm, o_alu_op);
    end
    checks++;
    if (dut_vec() !== exp_vec) begin
      errors++; $display("FAIL ori_vec got %h exp %h", dut_vec(), exp_vec);
    end
  endtask

  task automatic test_stall_flush();
    fetch(32'h2001_0011);                                         // A
    step(1'b1, 32'h2002_0022, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);     // stall
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL stall1_bubble got %b exp 0", o_valid);
    end
    step(1'b1, 32'h2002_0022, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);     // stall
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL stall2_bubble got %b exp 0", o_valid);
    end
    fetch(32'h2002_0022);                                         // B
    checks++;
    if (o_valid !== 1'b1 || o_imm !== 32'h11 || dut_vec() !== exp_vec) begin
      errors++; $display("FAIL stall_held_issue got %h exp %h", dut_vec(), exp_vec);
    end
    fetch(32'h2003_0033);
    checks++;
    if (o_imm !== 32'h22 || dut_vec() !== exp_vec) begin
      errors++; $display("FAIL stall_next got %h exp %h", dut_vec(), exp_vec);
    end
    fetch(32'h2004_0044);                                         // D into IF/ID
    step(1'b1, 32'h2005_0055, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);     // stall+flush
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL stall_flush_bubble got %b exp 0", o_valid);
    end
    idle();
    checks++;
    if (o_valid !== 1'b0 || dut_vec() !== exp_vec) begin
      errors++; $display("FAIL flush_lost got %h exp %h", dut_vec(), exp_vec);
    end
  endtask

  task automatic test_zero_illegal();
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    fetch(32'h2001_0000);  // addi $1,$0,0
    idle();
    checks++;
    if (o_rs_data !== 32'd0 || o_valid !== 1'b1) begin
      errors++; $display("FAIL reg0_read got %h exp 0", o_rs_data);
    end
    fetch(32'hFC00_0000);
    fetch(32'h0000_0000);  // NOP follows the illegal op
    checks++;
    if (o_illegal !== 1'b1 || o_reg_write !== 1'b0 || o_alu_src !== 1'b0 || dut_vec() !== exp_vec) begin
      errors++; $display("FAIL illegal got %h exp %h", dut_vec(), exp_vec);
    end
    idle();
    checks++;
    if (o_illegal !== 1'b0 || o_valid !== 1'b1 || o_reg_write !== 1'b0 || o_reg_dst !== 1'b1) begin
      errors++; $display("FAIL nop got ill %b v %b wr %b dst %b exp 0 1 0 1", o_illegal, o_valid, o_reg_write, o_reg_dst);
    end
  endtask

  task automatic test_random();
    logic [5:0]  ops [10];
    logic [31:0] ins;
    logic        v, st, fl, we;
    logic [4:0]  wa;
    int          bad;
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h02, 6'h3F};
    bad = 0;
    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      if ($urandom_range(7) != 0) ins[31:26] = ops[$urandom_range(9)];
      v  = ($urandom_range(3) != 0);
      st = ($urandom_range(7) == 0);
      fl = ($urandom_range(9) == 0);
      we = $urandom_range(1) != 0;
      wa = 5'($urandom_range(31));
      step(v, ins, st, fl, we, wa, $urandom);
      checks++;
      if (dut_vec() !== exp_vec) begin
        errors++;
        if (bad < 10) $display("FAIL random_%0d got %h exp %h", n, dut_vec(), exp_vec);
        bad++;
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd5, 32'hCAFE_0005);
    fetch(32'h00A5_3020);  // add $6,$5,$5 sitting in IF/ID
    do_reset(1);
    checks++;
    if (dut_vec() !== exp_vec) begin
      errors++; $display("FAIL reset_mid_state got %h exp %h", dut_vec(), exp_vec);
    end
    idle();
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid_ifid got %b exp 0", o_valid);
    end
    fetch(32'h00A5_3020);
    idle();
    checks++;
    if (o_rs_data !== 32'd0 || o_rt_data !== 32'd0 || dut_vec() !== exp_vec) begin
      errors++; $display("FAIL reset_mid_regs got rs %h rt %h exp 0 0", o_rs_data, o_rt_data);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_bypass();
    test_imm_ext();
    test_stall_flush();
    test_zero_illegal();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
